inst_queue: RTL
===============

// Module: inst_queue
// PURPOSE
//  Fetch/decode buffer directly upstream of the issue stage. Fetches 16-bit words from
//  instruction memory, holds them in a DEPTH-entry circular queue, and presents the
//  decoded head fields (func, rd, rs1, rs2) to issue through a valid/ready handshake.
//  A flush input empties the queue and redirects the PC for branch recovery.
// PARAMETERS
//  DEPTH  4   queue entries (power of 2, >=2)
//  PC_W   8   PC / imem address width; PC wraps modulo 2^PC_W
//  IW     16  instruction width; format {func[15:12], rd[11:8], rs1[7:4], rs2[3:0]}
// PORTS
//  clk1       in   1       single clock, all state on posedge
//  reset      in   1       asynchronous, active-high
//  fetch_en   in   1       permit a fetch this cycle
//  imem_addr  out  PC_W    current PC (combinational from pc register)
//  imem_rdata in   IW      word at imem_addr, valid in the same cycle
//  flush      in   1       discard queue contents, redirect PC
//  flush_pc   in   PC_W    new PC when flush=1
//  iss_valid  out  1       head entry present
//  iss_ready  in   1       issue accepts head (pop when iss_valid & iss_ready)
//  iss_func   out  4       head func  (0 when empty)
//  iss_rd     out  4       head rd    (0 when empty)
//  iss_rs1    out  4       head rs1   (0 when empty)
//  iss_rs2    out  4       head rs2   (0 when empty)
//  iss_pc     out  PC_W    PC of head instruction (0 when empty)
//  q_count    out  $clog2(DEPTH)+1  occupancy 0..DEPTH
//  halted     out  1       fetch stopped by halt word (always 0 without macro)
// BEHAVIOUR
//  - Reset (async): pc=0, head=tail=0, count=0, halted=0; iss_valid=0, all iss_* = 0.
//  - Storage per entry: {pc, word}. iss_* driven combinationally from the head entry.
//  - pop  = iss_valid & iss_ready.
//  - push = fetch_en & ~halted & (count<DEPTH | pop). On push: entry[tail] <= {pc, imem_rdata},
//    tail <= tail+1 (mod DEPTH), pc <= pc+1 (wraps 2^PC_W-1 -> 0).
//  - Simultaneous push+pop: count unchanged. Push into a full queue is legal only with a pop in
//    the same cycle. Pop from empty is impossible (iss_valid=0).
//  - Latency: word fetched at edge N is at the head, iss_valid=1, after edge N when the queue
//    was empty (1 cycle from fetch to visibility). No bypass from imem_rdata to iss_*.
//  - iss_ready may be held high; fields must remain stable while iss_valid=1 and ~iss_ready.
//  - Flush has priority over push and pop: head=tail=count=0, pc<=flush_pc, halted<=0,
//    no push that cycle; iss_valid=0 on the following cycle.
//  - fetch_en=0: pc holds, no push; pops continue.
//  - Reset asserted mid-operation discards all entries immediately; no partial state survives.
// CONFIGURATION
//  IQ_HALT_DETECT_EN defined: a pushed word with func==4'b1111 is queued normally, then halted<=1
//   on the same edge; fetching stops (pc holds) until flush or reset. The queue still drains.
//  IQ_HALT_DETECT_EN undefined: func 4'b1111 is an ordinary word; halted tied to 0.
// TESTING
//  1 reset, imem[0..3]=16'h0123,16'h1456,16'h2789,16'h3ABC, fetch_en=1, iss_ready=0 -> after 4
//    edges q_count=4, pc=4, head func=0 rd=1 rs1=2 rs2=3, further pushes blocked.
//  2 full queue, iss_ready=1 for 1 cycle with fetch_en=1 -> q_count stays 4, head becomes
//    16'h1456 (func=1), imem[4] enqueued at tail, pc=5.
//  3 pc=255 (PC_W=8), fetch_en=1 -> word at 255 pushed with iss_pc=255, next pc=0.
//  4 two entries queued, flush=1 with flush_pc=8'h40 and iss_ready=1 -> next cycle q_count=0,
//    iss_valid=0, imem_addr=8'h40; following fetch gives iss_pc=8'h40.
//  5 IQ_HALT_DETECT_EN, imem[2]=16'hF000 -> after 3 edges halted=1, pc=3 held; draining pops
//    yield 3 entries then iss_valid=0; flush clears halted and resumes fetch.
//  6 reset asserted asynchronously mid-stream with 3 entries -> iss_valid, q_count, imem_addr
//    go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//   Fetch/decode buffer that sits directly in front of the issue stage.
//   - Fetches one IW-bit word per cycle from instruction memory at the PC.
//   - Keeps {pc, word} pairs in a DEPTH-entry circular queue.
//   - Presents the decoded head fields to issue through a valid/ready handshake.
//   - A flush empties the queue and redirects the PC for branch recovery.
//   Optional feature macro: IQ_HALT_DETECT_EN. When it is defined, a fetched
//   word with func == 4'b1111 stops fetching until the next flush or reset.
//   When it is undefined, halted is always 0.
//
// Ports
//   clk1        in   single clock; all state changes on its rising edge
//   reset       in   asynchronous, active-high
//   fetch_en    in   permit a fetch this cycle
//   imem_addr   out  current PC, driven from the pc register
//   imem_rdata  in   word at imem_addr, valid in the same cycle
//   flush       in   discard the queue and load flush_pc into the PC
//   flush_pc    in   redirect target
//   iss_valid   out  head entry present
//   iss_ready   in   issue accepts the head (pop = iss_valid & iss_ready)
//   iss_func    out  head func; 0 when the queue is empty
//   iss_rd      out  head rd; 0 when the queue is empty
//   iss_rs1     out  head rs1; 0 when the queue is empty
//   iss_rs2     out  head rs2; 0 when the queue is empty
//   iss_pc      out  PC of the head instruction; 0 when the queue is empty
//   q_count     out  occupancy, 0..DEPTH
//   halted      out  fetch stopped by a halt word
// -----------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 8,
    parameter int IW    = 16
) (
    input  logic                     clk1,
    input  logic                     reset,
    input  logic                     fetch_en,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [IW-1:0]            imem_rdata,
    input  logic                     flush,
    input  logic [PC_W-1:0]          flush_pc,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [3:0]               iss_func,
    output logic [3:0]               iss_rd,
    output logic [3:0]               iss_rs1,
    output logic [3:0]               iss_rs2,
    output logic [PC_W-1:0]          iss_pc,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0]   PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
    localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1'b1);

    // State registers
    logic [PC_W-1:0] pc_r;
    logic [AW-1:0]   head_r;
    logic [AW-1:0]   tail_r;
    logic [CW-1:0]   count_r;
    logic            halted_r;
    logic [PC_W-1:0] ent_pc_r   [DEPTH];
    logic [IW-1:0]   ent_word_r [DEPTH];

    // Handshake and control terms
    logic            valid_s;
    logic            full_s;
    logic            pop_s;
    logic            push_s;
    logic            halt_hit_s;
    logic [IW-1:0]   head_word_s;
    logic [PC_W-1:0] head_pc_s;

    assign valid_s     = (count_r != {CW{1'b0}});
    assign full_s      = (count_r == CNT_FULL);
    assign pop_s       = valid_s & iss_ready;
    // A full queue can still accept a word when the head leaves in the same cycle.
    assign push_s      = fetch_en & ~halted_r & (~full_s | pop_s);
    assign head_word_s = ent_word_r[head_r];
    assign head_pc_s   = ent_pc_r[head_r];

`ifdef IQ_HALT_DETECT_EN
    // The halt word itself is queued; only subsequent fetches are stopped.
    assign halt_hit_s = push_s & (imem_rdata[IW-1 -: 4] == 4'b1111);
`else
    assign halt_hit_s = 1'b0;
`endif

    // PC, queue pointers, occupancy and halt flag; flush overrides push and pop
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            pc_r     <= {PC_W{1'b0}};
            head_r   <= {AW{1'b0}};
            tail_r   <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            halted_r <= 1'b0;
        end else if (flush) begin
            pc_r     <= flush_pc;
            head_r   <= {AW{1'b0}};
            tail_r   <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            halted_r <= 1'b0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
                pc_r   <= pc_r + PC_ONE;
            end else begin
                tail_r <= tail_r;
                pc_r   <= pc_r;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (halt_hit_s) begin
                halted_r <= 1'b1;
            end else begin
                halted_r <= halted_r;
            end
        end
    end

    // Entry storage: write {pc, word} at the tail on every accepted fetch
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_r[i]   <= {PC_W{1'b0}};
                ent_word_r[i] <= {IW{1'b0}};
            end
        end else if (push_s && !flush) begin
            ent_pc_r[tail_r]   <= pc_r;
            ent_word_r[tail_r] <= imem_rdata;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_r[i]   <= ent_pc_r[i];
                ent_word_r[i] <= ent_word_r[i];
            end
        end
    end

    // Decode the head entry; all fields read as zero while the queue is empty
    always_comb begin
        iss_func = 4'h0;
        iss_rd   = 4'h0;
        iss_rs1  = 4'h0;
        iss_rs2  = 4'h0;
        iss_pc   = {PC_W{1'b0}};
        if (valid_s) begin
            iss_func = head_word_s[IW-1 -: 4];
            iss_rd   = head_word_s[IW-5 -: 4];
            iss_rs1  = head_word_s[IW-9 -: 4];
            iss_rs2  = head_word_s[IW-13 -: 4];
            iss_pc   = head_pc_s;
        end else begin
            iss_func = 4'h0;
            iss_rd   = 4'h0;
            iss_rs1  = 4'h0;
            iss_rs2  = 4'h0;
            iss_pc   = {PC_W{1'b0}};
        end
    end

    assign imem_addr = pc_r;
    assign iss_valid = valid_s;
    assign q_count   = count_r;
    assign halted    = halted_r;

endmodule
